// File: rtl/pin_input_monitor_pkg.sv
// Shared pin-map types and register offsets for the input pin monitor.
package pin_input_monitor_pkg;
  localparam int unsigned IN_PIN_NUM = 8;

  typedef logic [IN_PIN_NUM-1:0] sonata_in_pins_t;

  localparam logic [4:0] PIN_MON_LEVEL       = 5'h00;
  localparam logic [4:0] PIN_MON_RAW         = 5'h04;
  localparam logic [4:0] PIN_MON_RISE_EN     = 5'h08;
  localparam logic [4:0] PIN_MON_FALL_EN     = 5'h0C;
  localparam logic [4:0] PIN_MON_RISE_STATUS = 5'h10;
  localparam logic [4:0] PIN_MON_FALL_STATUS = 5'h14;
endpackage

// File: rtl/pin_input_monitor_debounce.sv
// One pin: two-flop synchroniser, stable-cycle counter and debounced level with edge strobes.
module pin_debounce #(
  parameter int unsigned DebounceCycles = 16,
  parameter logic        ResetValue     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic raw_o,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CntW = (DebounceCycles > 0) ? $clog2(DebounceCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (DebounceCycles > 0) ? CntW'(DebounceCycles - 1) : '0;

  logic            sync_q;
  logic            raw_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while raw disagrees with level, so it can never pass CntLast.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (DebounceCycles == 0) begin
      level_d = raw_q;
    end else if (raw_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = raw_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= ResetValue;
      raw_q   <= ResetValue;
      level_q <= ResetValue;
      cnt_q   <= '0;
    end else begin
      sync_q  <= pin_i;
      raw_q   <= sync_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign raw_o   = raw_q;
  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;
  assign fall_o  = ~level_d & level_q;
endmodule

// File: rtl/pin_input_monitor.sv
// Input pin monitor: per-pin debounce, sticky enabled edge status, level irq and a small register port.
module pin_input_monitor
  import pin_input_monitor_pkg::*;
#(
  parameter int unsigned        NumPins        = IN_PIN_NUM,
  parameter int unsigned        DebounceCycles = 16,
  parameter logic [NumPins-1:0] ResetValue     = '1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPins-1:0] pins_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [4:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic               reg_rvalid_o,
  output logic [31:0]        reg_rdata_o,
  output logic               irq_o
);
  logic [NumPins-1:0] raw, level, rise, fall;

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    pin_debounce #(
      .DebounceCycles(DebounceCycles),
      .ResetValue    (ResetValue[i])
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pin_i  (pins_i[i]),
      .raw_o  (raw[i]),
      .level_o(level[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  logic [NumPins-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NumPins-1:0] rise_st_q, rise_st_d, fall_st_q, fall_st_d;
  logic [NumPins-1:0] wdata, rise_clr, fall_clr;
  logic [31:0]        rd_val, rdata_q, rdata_d;
  logic [4:0]         word;
  logic               wr_en, rvalid_q, irq_q, irq_d;

  assign word  = {reg_addr_i[4:2], 2'b00};
  assign wr_en = reg_req_i & reg_we_i;
  assign wdata = reg_wdata_i[NumPins-1:0];

  always_comb begin
    rd_val    = '0;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    rise_clr  = '0;
    fall_clr  = '0;
    case (word)
      PIN_MON_LEVEL:       rd_val = 32'(level);
      PIN_MON_RAW:         rd_val = 32'(raw);
      PIN_MON_RISE_EN:     rd_val = 32'(rise_en_q);
      PIN_MON_FALL_EN:     rd_val = 32'(fall_en_q);
      PIN_MON_RISE_STATUS: rd_val = 32'(rise_st_q);
      PIN_MON_FALL_STATUS: rd_val = 32'(fall_st_q);
      default:             rd_val = '0;
    endcase
    rdata_d = (reg_req_i && !reg_we_i) ? rd_val : '0;
    if (wr_en) begin
      if (word == PIN_MON_RISE_EN)     rise_en_d = wdata;
      if (word == PIN_MON_FALL_EN)     fall_en_d = wdata;
      if (word == PIN_MON_RISE_STATUS) rise_clr  = wdata;
      if (word == PIN_MON_FALL_STATUS) fall_clr  = wdata;
    end
    // A new edge in the same cycle as its W1C keeps the bit set.
    rise_st_d = (rise_st_q & ~rise_clr) | (rise & rise_en_q);
    fall_st_d = (fall_st_q & ~fall_clr) | (fall & fall_en_q);
    irq_d     = |(rise_st_q | fall_st_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      rise_st_q <= '0;
      fall_st_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      rise_st_q <= rise_st_d;
      fall_st_q <= fall_st_d;
      rvalid_q  <= reg_req_i;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign irq_o        = irq_q;

  logic unused_addr;
  assign unused_addr = ^reg_addr_i[1:0];
  if (NumPins < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i[31:NumPins];
  end
endmodule

// File: tb/tb_pin_input_monitor.sv
// Bench for pin_input_monitor: register table, directed timing sequences and a randomized run against a reference model.
module tb_pin_input_monitor;
  localparam int NP = 8;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] pins = '1;
  logic          req = 1'b0, we = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          rvalid, irq;
  logic [31:0]   rdata;

  always #5 clk = ~clk;

  pin_input_monitor #(.NumPins(NP), .DebounceCycles(DC), .ResetValue('1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pins_i(pins),
    .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rvalid_o(rvalid), .reg_rdata_o(rdata), .irq_o(irq)
  );

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: raw is the pad delayed two clocks; level follows raw once raw
  // has held one value for DC consecutive cycles.
  logic [NP-1:0] m_s1, m_raw, m_last, m_level, m_ren, m_fen, m_rst, m_fst, nl, clr;
  int            run [NP];
  logic          m_rvalid, m_irq;
  logic [31:0]   m_rdata, rv;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '1; m_raw = '1; m_last = '1; m_level = '1;
      m_ren = '0; m_fen = '0; m_rst = '0; m_fst = '0;
      m_rvalid = 1'b0; m_rdata = '0; m_irq = 1'b0;
      for (int i = 0; i < NP; i++) run[i] = 0;
    end else begin
      case (addr[4:2])
        3'd0: rv = 32'(m_level);
        3'd1: rv = 32'(m_raw);
        3'd2: rv = 32'(m_ren);
        3'd3: rv = 32'(m_fen);
        3'd4: rv = 32'(m_rst);
        3'd5: rv = 32'(m_fst);
        default: rv = '0;
      endcase
      m_rvalid = req;
      m_rdata  = (req && !we) ? rv : '0;
      m_irq    = |(m_rst | m_fst);
      nl = m_level;
      for (int i = 0; i < NP; i++) begin
        if (m_raw[i] === m_last[i]) begin
          if (run[i] < 1000) run[i]++;
        end else run[i] = 1;
        m_last[i] = m_raw[i];
        if (m_raw[i] !== m_level[i] && run[i] >= DC) nl[i] = m_raw[i];
      end
      clr = (req && we && addr[4:2] == 3'd4) ? wdata[NP-1:0] : '0;
      m_rst = (m_rst & ~clr) | (nl & ~m_level & m_ren);
      clr = (req && we && addr[4:2] == 3'd5) ? wdata[NP-1:0] : '0;
      m_fst = (m_fst & ~clr) | (~nl & m_level & m_fen);
      if (req && we && addr[4:2] == 3'd2) m_ren = wdata[NP-1:0];
      if (req && we && addr[4:2] == 3'd3) m_fen = wdata[NP-1:0];
      m_level = nl;
      m_raw   = m_s1;
      m_s1    = pins;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("model irq", 32'(irq), 32'(m_irq));
      if (m_rvalid) chk("model rdata", rdata, m_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a; wdata = '0;
    cyc();
    chk({nm, " rvalid"}, 32'(rvalid), 32'd1);
    chk(nm, rdata, exp);
    req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    chk("wr rvalid", 32'(rvalid), 32'd1);
    chk("wr rdata", rdata, 32'd0);
    req = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b0, 5'h00, 32'h0,   32'hFF};
    tbl[1]  = '{1'b1, 5'h08, 32'hFF,  32'h0};
    tbl[2]  = '{1'b0, 5'h08, 32'h0,   32'hFF};
    tbl[3]  = '{1'b0, 5'h1C, 32'h0,   32'h0};
    tbl[4]  = '{1'b0, 5'h04, 32'h0,   32'hFF};
    tbl[5]  = '{1'b0, 5'h0C, 32'h0,   32'h0};
    tbl[6]  = '{1'b0, 5'h10, 32'h0,   32'h0};
    tbl[7]  = '{1'b0, 5'h17, 32'h0,   32'h0};
    tbl[8]  = '{1'b1, 5'h00, 32'h0,   32'h0};
    tbl[9]  = '{1'b0, 5'h00, 32'h0,   32'hFF};
    tbl[10] = '{1'b1, 5'h0C, 32'h1A5, 32'h0};
    tbl[11] = '{1'b0, 5'h0E, 32'h0,   32'hA5};
    tbl[12] = '{1'b1, 5'h18, 32'hFF,  32'h0};
    tbl[13] = '{1'b0, 5'h18, 32'h0,   32'h0};
    tbl[14] = '{1'b1, 5'h08, 32'h0,   32'h0};
    tbl[15] = '{1'b0, 5'h08, 32'h0,   32'h0};
    tbl[16] = '{1'b1, 5'h0C, 32'h0,   32'h0};

    // Reset and idle-high hold
    repeat (3) cyc();
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      cyc();
      chk("idle irq", 32'(irq), 32'd0);
    end

    // Back-to-back register table
    for (int i = 0; i < 17; i++) begin
      req = 1'b1; we = tbl[i].we; addr = tbl[i].a; wdata = tbl[i].d;
      cyc();
      chk($sformatf("tbl[%0d] rvalid", i), 32'(rvalid), 32'd1);
      chk($sformatf("tbl[%0d] rdata", i), rdata, tbl[i].exp);
    end
    req = 1'b0; we = 1'b0;
    cyc();
    chk("tbl rvalid drop", 32'(rvalid), 32'd0);

    // 15-cycle glitch on pin3 is rejected
    wr(5'h0C, 32'h08);
    pins[3] = 1'b0;
    repeat (15) cyc();
    pins[3] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      cyc();
      chk("glitch irq", 32'(irq), 32'd0);
    end
    rdchk("glitch LEVEL", 5'h00, 32'hFF);
    rdchk("glitch FALL_STATUS", 5'h14, 32'h0);

    // Pin0 fall: exact debounce latency, status, irq one cycle later
    wr(5'h0C, 32'h01);
    pins[0] = 1'b0;
    repeat (17) cyc();
    rdchk("fall LEVEL before", 5'h00, 32'hFF);
    chk("fall irq early", 32'(irq), 32'd0);
    rdchk("fall LEVEL after", 5'h00, 32'hFE);
    chk("fall irq", 32'(irq), 32'd1);
    rdchk("fall FALL_STATUS", 5'h14, 32'h01);
    rdchk("fall RISE_STATUS", 5'h10, 32'h0);

    // W1C on the same cycle as a new enabled fall: set wins
    pins[0] = 1'b1;
    repeat (25) cyc();
    rdchk("rise unenabled", 5'h10, 32'h0);
    pins[0] = 1'b0;
    repeat (17) cyc();
    wr(5'h14, 32'h01);
    rdchk("set wins", 5'h14, 32'h01);
    chk("set wins irq", 32'(irq), 32'd1);
    wr(5'h14, 32'h01);
    chk("clear irq lag", 32'(irq), 32'd1);
    cyc();
    chk("clear irq drop", 32'(irq), 32'd0);
    rdchk("cleared FALL_STATUS", 5'h14, 32'h0);

    // Reset mid-debounce with status pending
    wr(5'h08, 32'hFF);
    wr(5'h0C, 32'hFF);
    pins[1] = 1'b0;
    repeat (20) cyc();
    rdchk("pre-reset FALL_STATUS", 5'h14, 32'h02);
    pins[2] = 1'b0;
    repeat (8) cyc();
    req = 1'b1; we = 1'b0; addr = 5'h00;
    cyc();
    req = 1'b0;
    chk("pre-reset rvalid", 32'(rvalid), 32'd1);
    chk("pre-reset irq", 32'(irq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async irq", 32'(irq), 32'd0);
    chk("async rvalid", 32'(rvalid), 32'd0);
    chk("async rdata", rdata, 32'd0);
    pins = '1;
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      chk("post-reset irq", 32'(irq), 32'd0);
    end
    rdchk("post-reset LEVEL", 5'h00, 32'hFF);
    rdchk("post-reset RISE_EN", 5'h08, 32'h0);
    rdchk("post-reset FALL_EN", 5'h0C, 32'h0);
    rdchk("post-reset RISE_STATUS", 5'h10, 32'h0);
    rdchk("post-reset FALL_STATUS", 5'h14, 32'h0);

    // Randomized traffic against the model
    wr(5'h08, 32'($urandom));
    wr(5'h0C, 32'($urandom));
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NP; b++)
        if ($urandom_range(0, 39) == 0) pins[b] = ~pins[b];
      req   = ($urandom_range(0, 2) == 0);
      we    = 1'($urandom_range(0, 1));
      addr  = 5'($urandom_range(0, 31));
      wdata = $urandom;
      if (we && (addr[4:2] == 3'd4 || addr[4:2] == 3'd5) && $urandom_range(0, 3) != 0) we = 1'b0;
      cyc();
    end
    req = 1'b0; we = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
